// File: rtl/spi_master_seq.sv
// rtl/spi_master_seq.sv - command sequencer feeding one SPI master transfer at a time

// Command queue: power-of-2 circular buffer with a registered occupancy count.
module spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count only; a same-cycle pop does not free a slot early.
  assign push_ready = (level != LW'(DEPTH));
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && (level != '0);
  assign pop_data   = mem[rd_ptr];

  // Entry storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// Launches queued commands on the master, collects results, enforces an idle gap and a watchdog.
module spi_master_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2,
  parameter int TIMEOUT    = 2048
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_len,
  input  logic [3:0]                    cmd_period,
  input  logic                          cmd_loop,
  input  logic [31:0]                   cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_data,
  output logic                          rsp_timeout,
  output logic                          spi_start,
  output logic [3:0]                    spi_len,
  output logic [3:0]                    spi_period,
  output logic                          spi_loop,
  output logic [31:0]                   spi_odata,
  input  logic                          spi_end,
  input  logic [31:0]                   spi_idata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(GAP) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_GAP} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [40:0]   head;
  logic          fifo_pop;

  assign fifo_pop = (state == ST_IDLE) && (fifo_level != '0);

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (41)
  ) u_cmd_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .push_data  ({cmd_len, cmd_period, cmd_loop, cmd_data}),
    .pop        (fifo_pop),
    .pop_data   (head),
    .level      (fifo_level)
  );

  // Transfer sequencer: launch, wait for end or watchdog, hold response, then idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      spi_start   <= 1'b0;
      spi_len     <= '0;
      spi_period  <= '0;
      spi_loop    <= 1'b0;
      spi_odata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_level != '0) begin
            {spi_len, spi_period, spi_loop, spi_odata} <= head;
            spi_start <= 1'b1;
            tmo_cnt   <= '0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (spi_end) begin
            rsp_data    <= spi_idata;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            spi_start   <= 1'b0;
            state       <= ST_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_data    <= spi_idata;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            spi_start   <= 1'b0;
            state       <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            gap_cnt   <= GAP_LOAD;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
